// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared line width, address width default and FSM encoding
//  Revision : 1.0
// ============================================================================
package mem_arbiter_pkg;

    localparam int c_LINE_W         = 128;
    localparam int c_ADDR_W_DEFAULT = 28;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    // Encoding of the last_grant flag
    localparam logic c_GNT_I = 1'b0;
    localparam logic c_GNT_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin selector between I-side and D-side requests
//  Revision : 1.0
// ============================================================================
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_last_grant,
    output logic o_gnt_i,
    output logic o_gnt_d
);

    // On a tie the side that did not win last time is chosen
    assign o_gnt_d = i_req_d & (~i_req_i | (i_last_grant == c_GNT_I));
    assign o_gnt_i = i_req_i & (~i_req_d | (i_last_grant == c_GNT_D));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Arbitrates I-cache and D-cache line traffic onto one memory port
//  Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT
) (
    input  logic                clk,
    input  logic                proc_reset,
    input  logic                i_mem_read,
    input  logic [ADDR_W-1:0]   i_mem_addr,
    output logic [c_LINE_W-1:0] i_mem_rdata,
    output logic                i_mem_ready,
    input  logic                d_mem_read,
    input  logic                d_mem_write,
    input  logic [ADDR_W-1:0]   d_mem_addr,
    input  logic [c_LINE_W-1:0] d_mem_wdata,
    output logic [c_LINE_W-1:0] d_mem_rdata,
    output logic                d_mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [c_LINE_W-1:0] mem_wdata,
    input  logic [c_LINE_W-1:0] mem_rdata,
    input  logic                mem_ready
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_grant, w_last_grant_nxt;
    logic                r_mem_read,   w_mem_read_nxt;
    logic                r_mem_write,  w_mem_write_nxt;
    logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr_nxt;
    logic [c_LINE_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
    logic                w_gnt_i, w_gnt_d;

    rr_arb2 u_rr_arb2 (
        .i_req_i      (i_mem_read),
        .i_req_d      (d_mem_read | d_mem_write),
        .i_last_grant (r_last_grant),
        .o_gnt_i      (w_gnt_i),
        .o_gnt_d      (w_gnt_d)
    );

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_mem_read_nxt   = r_mem_read;
        w_mem_write_nxt  = r_mem_write;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        case (r_state)
            IDLE: begin
                if (w_gnt_i) begin
                    w_state_nxt      = SERVE_I;
                    w_last_grant_nxt = c_GNT_I;
                    w_mem_read_nxt   = 1'b1;
                    w_mem_write_nxt  = 1'b0;
                    w_mem_addr_nxt   = i_mem_addr;
                    w_mem_wdata_nxt  = '0;
                end else if (w_gnt_d) begin
                    // A write wins over a simultaneous read from the D side
                    w_state_nxt      = SERVE_D;
                    w_last_grant_nxt = c_GNT_D;
                    w_mem_read_nxt   = ~d_mem_write;
                    w_mem_write_nxt  = d_mem_write;
                    w_mem_addr_nxt   = d_mem_addr;
                    w_mem_wdata_nxt  = d_mem_write ? d_mem_wdata : '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_ready) begin
                    w_state_nxt     = IDLE;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_mem_read_nxt  = 1'b0;
                w_mem_write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_last_grant <= c_GNT_I;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_mem_read   <= w_mem_read_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;
    assign i_mem_ready = (r_state == SERVE_I) & mem_ready;
    assign d_mem_ready = (r_state == SERVE_D) & mem_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter
//  Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 28;

    logic           clk = 1'b0;
    logic           proc_reset;
    logic           i_mem_read;
    logic [AW-1:0]  i_mem_addr;
    logic [127:0]   i_mem_rdata;
    logic           i_mem_ready;
    logic           d_mem_read, d_mem_write;
    logic [AW-1:0]  d_mem_addr;
    logic [127:0]   d_mem_wdata;
    logic [127:0]   d_mem_rdata;
    logic           d_mem_ready;
    logic           mem_read, mem_write;
    logic [AW-1:0]  mem_addr;
    logic [127:0]   mem_wdata;
    logic [127:0]   mem_rdata;
    logic           mem_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] c_LINE1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] c_LINE3 = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
    localparam logic [127:0] c_WD1   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] c_WD2   = 128'h0BADF00D_00000000_FEEDFACE_00000055;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .proc_reset  (proc_reset),
        .i_mem_read  (i_mem_read),
        .i_mem_addr  (i_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ready (i_mem_ready),
        .d_mem_read  (d_mem_read),
        .d_mem_write (d_mem_write),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_rdata (d_mem_rdata),
        .d_mem_ready (d_mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        proc_reset = 1'b1;
        step(); step();
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            errors++; $display("FAIL reset_cmd: got %b expected 00", {mem_read, mem_write});
        end
        checks++;
        if (mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
            errors++; $display("FAIL reset_data: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_mem_ready, d_mem_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {i_mem_ready, d_mem_ready});
        end
        mem_ready  = 1'b0;
        proc_reset = 1'b0;
        step();
    endtask

    task automatic test_i_read();
        i_mem_read = 1'b1; i_mem_addr = 28'h0000010;
        step();
        checks++;
        if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h0000010 || mem_wdata !== 128'h0) begin
            errors++; $display("FAIL i_read_cmd: got rd%b wr%b addr %h wd %h expected rd1 wr0 addr 0000010 wd 0",
                               mem_read, mem_write, mem_addr, mem_wdata);
        end
        step(); step();
        mem_ready = 1'b1; mem_rdata = c_LINE1;
        #1;
        checks++;
        if (i_mem_ready !== 1'b1 || d_mem_ready !== 1'b0 || i_mem_rdata !== c_LINE1) begin
            errors++; $display("FAIL i_read_ready: got i%b d%b data %h expected i1 d0 data %h",
                               i_mem_ready, d_mem_ready, i_mem_rdata, c_LINE1);
        end
        step();
        i_mem_read = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (i_mem_ready !== 1'b0 || mem_read !== 1'b0) begin
            errors++; $display("FAIL i_read_done: got ready %b mem_read %b expected 0 0", i_mem_ready, mem_read);
        end
        step();
    endtask

    task automatic test_tie();
        d_mem_read = 1'b1; d_mem_addr = 28'h0000020;
        i_mem_read = 1'b1; i_mem_addr = 28'h0000010;
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000020) begin
            errors++; $display("FAIL tie1_winner: got rd %b addr %h expected rd 1 addr 0000020", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_mem_ready, d_mem_ready} !== 2'b01) begin
            errors++; $display("FAIL tie1_ready: got i/d %b expected 01", {i_mem_ready, d_mem_ready});
        end
        step();
        mem_ready = 1'b0; d_mem_read = 1'b0;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            errors++; $display("FAIL tie_gap: got %b expected 00", {mem_read, mem_write});
        end
        // D comes back in the idle cycle: second tie, D won last so I goes first
        d_mem_read = 1'b1; d_mem_addr = 28'h0000040;
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000010) begin
            errors++; $display("FAIL tie2_winner: got rd %b addr %h expected rd 1 addr 0000010", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_mem_ready, d_mem_ready} !== 2'b10) begin
            errors++; $display("FAIL tie2_ready: got i/d %b expected 10", {i_mem_ready, d_mem_ready});
        end
        step();
        i_mem_read = 1'b0; mem_ready = 1'b0;
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000040) begin
            errors++; $display("FAIL tie2_second: got rd %b addr %h expected rd 1 addr 0000040", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_mem_ready !== 1'b1) begin
            errors++; $display("FAIL tie2_second_ready: got %b expected 1", d_mem_ready);
        end
        step();
        d_mem_read = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_write_defer();
        d_mem_write = 1'b1; d_mem_addr = 28'h00000AB; d_mem_wdata = c_WD1;
        step();
        checks++;
        if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 28'h00000AB || mem_wdata !== c_WD1) begin
            errors++; $display("FAIL write_cmd: got rd%b wr%b addr %h wd %h expected rd0 wr1 addr 00000AB wd %h",
                               mem_read, mem_write, mem_addr, mem_wdata, c_WD1);
        end
        i_mem_read = 1'b1; i_mem_addr = 28'h0000077;
        step(); step();
        checks++;
        if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 28'h00000AB) begin
            errors++; $display("FAIL write_hold: got rd%b wr%b addr %h expected rd0 wr1 addr 00000AB",
                               mem_read, mem_write, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_mem_ready, d_mem_ready} !== 2'b01) begin
            errors++; $display("FAIL write_ready: got i/d %b expected 01", {i_mem_ready, d_mem_ready});
        end
        step();
        d_mem_write = 1'b0; mem_ready = 1'b0;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            errors++; $display("FAIL write_gap: got %b expected 00", {mem_read, mem_write});
        end
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000077) begin
            errors++; $display("FAIL deferred_i: got rd %b addr %h expected rd 1 addr 0000077", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        step();
        i_mem_read = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_rw_resolve();
        d_mem_read = 1'b1; d_mem_write = 1'b1;
        d_mem_addr = 28'h0000055; d_mem_wdata = c_WD2;
        step();
        checks++;
        if ({mem_read, mem_write} !== 2'b01) begin
            errors++; $display("FAIL rw_resolve: got rd/wr %b expected 01", {mem_read, mem_write});
        end
        d_mem_addr = 28'h0000066; d_mem_wdata = 128'h0;
        step();
        checks++;
        if (mem_addr !== 28'h0000055 || mem_wdata !== c_WD2) begin
            errors++; $display("FAIL rw_stable: got addr %h wd %h expected addr 0000055 wd %h", mem_addr, mem_wdata, c_WD2);
        end
        d_mem_read = 1'b0; d_mem_write = 1'b0;
        step();
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 28'h0000055) begin
            errors++; $display("FAIL withdraw_hold: got wr %b addr %h expected wr 1 addr 0000055", mem_write, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_mem_ready !== 1'b1) begin
            errors++; $display("FAIL withdraw_ready: got %b expected 1", d_mem_ready);
        end
        step();
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        i_mem_read = 1'b1; i_mem_addr = 28'h0000030;
        step(); step(); step();
        proc_reset = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b00 || mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
            errors++; $display("FAIL midreset_clear: got rd%b wr%b addr %h wd %h expected all 0",
                               mem_read, mem_write, mem_addr, mem_wdata);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_mem_ready, d_mem_ready} !== 2'b00) begin
            errors++; $display("FAIL midreset_ready: got i/d %b expected 00", {i_mem_ready, d_mem_ready});
        end
        step();
        proc_reset = 1'b0; mem_ready = 1'b0; i_mem_read = 1'b0;
        step();
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_mem_ready, d_mem_ready} !== 2'b00) begin
            errors++; $display("FAIL late_ready: got i/d %b expected 00", {i_mem_ready, d_mem_ready});
        end
        step();
        mem_ready = 1'b0;
        i_mem_read = 1'b1; i_mem_addr = 28'h0000031;
        d_mem_read = 1'b1; d_mem_addr = 28'h0000032;
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000032) begin
            errors++; $display("FAIL post_reset_tie: got rd %b addr %h expected rd 1 addr 0000032", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; i_mem_read = 1'b0; d_mem_read = 1'b0;
        step();
    endtask

    task automatic test_spurious();
        mem_rdata = c_LINE3; mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_mem_ready, d_mem_ready} !== 2'b00 || d_mem_rdata !== c_LINE3 || i_mem_rdata !== c_LINE3) begin
            errors++; $display("FAIL spurious_ready: got i/d %b drd %h ird %h expected 00 and %h",
                               {i_mem_ready, d_mem_ready}, d_mem_rdata, i_mem_rdata, c_LINE3);
        end
        step();
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            errors++; $display("FAIL spurious_cmd: got %b expected 00", {mem_read, mem_write});
        end
        mem_ready = 1'b0;
        i_mem_read = 1'b1; i_mem_addr = 28'h0000099;
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000099) begin
            errors++; $display("FAIL spurious_idle: got rd %b addr %h expected rd 1 addr 0000099", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        step();
        i_mem_read = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    initial begin
        proc_reset  = 1'b1;
        i_mem_read  = 1'b0; i_mem_addr  = '0;
        d_mem_read  = 1'b0; d_mem_write = 1'b0;
        d_mem_addr  = '0;   d_mem_wdata = '0;
        mem_rdata   = '0;   mem_ready   = 1'b0;

        test_reset();
        test_i_read();
        test_tie();
        test_write_defer();
        test_rw_resolve();
        test_reset_mid();
        test_spurious();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter line: ADDR_W, 28, memory line-address width in 128-bit line units.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 proc_reset  input  1  asynchronous, active-high reset.
REQ-004 i_mem_read  input  1  I-cache line-fetch request, level, held until its ready.
REQ-005 i_mem_addr  input  ADDR_W  I-cache line address.
REQ-006 i_mem_rdata  output  128  read data returned to the I-cache.
REQ-007 i_mem_ready  output  1  one-cycle completion pulse to the I-cache.
REQ-008 d_mem_read, d_mem_write  input  1 each  D-cache fill and write-back requests, level, held until ready.
REQ-009 d_mem_addr  input  ADDR_W  D-cache line address.
REQ-010 d_mem_wdata  input  128  D-cache write-back line.
REQ-011 d_mem_rdata  output  128  read data returned to the D-cache.
REQ-012 d_mem_ready  output  1  one-cycle completion pulse to the D-cache.
REQ-013 mem_read, mem_write  output  1 each  registered command to the shared memory.
REQ-014 mem_addr  output  ADDR_W  registered memory address.
REQ-015 mem_wdata  output  128  registered write data.
REQ-016 mem_rdata  input  128  memory read data.
REQ-017 mem_ready  input  1  memory completion pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, SERVE_I and SERVE_D.
REQ-019 IDLE: i_mem_read alone -> SERVE_I; d_mem_read or d_mem_write alone -> SERVE_D; no request -> IDLE.
REQ-020 IDLE with both sides requesting SHALL grant the side not recorded in last_grant (round-robin).
REQ-021 last_grant SHALL update to the granted side on every IDLE->SERVE transition.
REQ-022 On the grant edge, mem_read, mem_write, mem_addr and mem_wdata SHALL be registered from the winner; latency is 1 cycle from request seen in IDLE to command visible.
REQ-023 SERVE_I SHALL drive mem_read=1, mem_write=0 and mem_wdata=0.
REQ-024 If d_mem_write=1 at grant, SERVE_D SHALL issue a write (mem_write=1, mem_read=0); otherwise it SHALL issue a read.
REQ-025 Simultaneous d_mem_read and d_mem_write SHALL resolve to the write.
REQ-026 Registered memory outputs SHALL remain stable throughout SERVE_x until mem_ready, regardless of requester input changes.
REQ-027 mem_ready in SERVE_I SHALL be forwarded combinationally to i_mem_ready only; mem_ready in SERVE_D SHALL be forwarded to d_mem_ready only.
REQ-028 mem_rdata SHALL be driven to both i_mem_rdata and d_mem_rdata continuously.
REQ-029 On a mem_ready edge in SERVE_x, the FSM SHALL enter IDLE and clear mem_read and mem_write.
REQ-030 At least one idle cycle (mem_read=mem_write=0) SHALL separate consecutive transactions.
REQ-031 The served requester SHALL drop its request on the edge at which it sees ready; a request still high in IDLE is a new transaction.
REQ-032 mem_ready in IDLE SHALL be ignored and SHALL NOT be forwarded.
REQ-033 A request withdrawn during SERVE_x SHALL NOT abort the transaction.
REQ-034 There is no timeout: SERVE_x SHALL wait indefinitely for mem_ready.

Reset
REQ-035 proc_reset=1 SHALL asynchronously force IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0 and last_grant=I, so D wins the first tie.
REQ-036 During reset, i_mem_ready and d_mem_ready SHALL be 0.
REQ-037 Reset asserted mid-transaction SHALL abandon it, and no ready SHALL be forwarded for it afterwards.

Structure
REQ-038 A shared package SHALL hold the state encoding (IDLE=2'd0, SERVE_I=2'd1, SERVE_D=2'd2), the 128-bit line width and the ADDR_W default.
REQ-039 The block SHALL be a single flat module; the round-robin selector MAY be split out as sub-module rr_arb2.

Verification
REQ-040 Reset, then i_mem_read=1 with addr 0x0000010 and a memory with 3-cycle latency -> mem_read=1 and mem_addr=0x0000010 one cycle later; i_mem_ready pulses once carrying mem_rdata; d_mem_ready stays 0.
REQ-041 Both sides request from IDLE after reset (D read 0x0000020, I read 0x0000010) -> D served first, one idle cycle, then I served; on a second simultaneous request, I is served first.
REQ-042 d_mem_write=1, addr 0x00000AB, wdata 0xDEADBEEF_...: mem_write=1, mem_read=0, wdata matches; i_mem_read raised mid-transaction is deferred until after d_mem_ready.
REQ-043 d_mem_read=d_mem_write=1 -> a write is issued; d_mem_addr changed during SERVE_D -> mem_addr is unchanged.
REQ-044 proc_reset pulsed two cycles into SERVE_I -> outputs are zero immediately, a later mem_ready is not forwarded, and after release D wins the next tie.
REQ-045 A spurious mem_ready in IDLE -> both ready outputs stay 0 and the state stays IDLE.
